// File: rtl/wb_register_bank_pkg.sv
// Shared definitions for the write-back stage / register file slice:
// default widths, architectural register numbers and dump FSM encoding.
package wb_register_bank_pkg;

  localparam int unsigned DEFAULT_NB_DATA = 32;
  localparam int unsigned DEFAULT_NB_REG  = 5;
  localparam int unsigned DEFAULT_NB_PC   = 32;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_RA   = 31;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SEND = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/wb_register_bank_register_array.sv
// Architectural register storage: one write port, three combinational read
// ports with same-cycle write-through; register 0 is hardwired to zero.
module register_array
  import wb_register_bank_pkg::*;
#(
  parameter int unsigned NB_DATA = DEFAULT_NB_DATA,
  parameter int unsigned NB_REG  = DEFAULT_NB_REG
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_we,
  input  logic [NB_REG-1:0]  i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [NB_REG-1:0]  i_rs_addr,
  input  logic [NB_REG-1:0]  i_rt_addr,
  input  logic [NB_REG-1:0]  i_dump_addr,
  output logic [NB_DATA-1:0] o_rs_data_c,
  output logic [NB_DATA-1:0] o_rt_data_c,
  output logic [NB_DATA-1:0] o_dump_data_c
);

  localparam int unsigned       N_REGS    = 2 ** NB_REG;
  localparam logic [NB_REG-1:0] ZERO_ADDR = NB_REG'(REG_ZERO);

  logic [NB_DATA-1:0] r_regs [N_REGS];
  logic               w_commit;

  // Writes to r0 are dropped here so the entry never leaves zero.
  assign w_commit = i_we && (i_waddr != ZERO_ADDR);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rs_data_c   = (i_rs_addr == ZERO_ADDR)                 ? '0      :
                         (w_commit && (i_waddr == i_rs_addr))     ? i_wdata :
                                                                    r_regs[i_rs_addr];
  assign o_rt_data_c   = (i_rt_addr == ZERO_ADDR)                 ? '0      :
                         (w_commit && (i_waddr == i_rt_addr))     ? i_wdata :
                                                                    r_regs[i_rt_addr];
  assign o_dump_data_c = (i_dump_addr == ZERO_ADDR)               ? '0      :
                         (w_commit && (i_waddr == i_dump_addr))   ? i_wdata :
                                                                    r_regs[i_dump_addr];

endmodule

// File: rtl/wb_register_bank.sv
// Write-back stage of the MIPS pipeline: write-back mux, register file
// and a debug dump sequencer streaming all registers over valid/ready.
module wb_register_bank
  import wb_register_bank_pkg::*;
#(
  parameter int unsigned NB_DATA = DEFAULT_NB_DATA,
  parameter int unsigned NB_REG  = DEFAULT_NB_REG,
  parameter int unsigned NB_PC   = DEFAULT_NB_PC
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_WB_reg_write,
  input  logic               i_WB_mem_to_reg,
  input  logic [NB_DATA-1:0] i_WB_mem_data,
  input  logic [NB_DATA-1:0] i_WB_alu_result,
  input  logic [NB_REG-1:0]  i_WB_selected_reg,
  input  logic               i_WB_r31_ctrl,
  input  logic [NB_PC-1:0]   i_WB_pc,
  input  logic [NB_REG-1:0]  i_ID_rs_addr,
  input  logic [NB_REG-1:0]  i_ID_rt_addr,
  output logic [NB_DATA-1:0] o_ID_rs_data,
  output logic [NB_DATA-1:0] o_ID_rt_data,
  output logic [NB_DATA-1:0] o_WB_write_data,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic               o_dump_valid,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic [NB_REG-1:0]  o_dump_index,
  output logic               o_dump_done
);

  localparam logic [NB_REG-1:0] ZERO_ADDR = NB_REG'(REG_ZERO);
  localparam logic [NB_REG-1:0] RA_ADDR   = NB_REG'(REG_RA);
  localparam logic [NB_REG-1:0] LAST_IDX  = '1;

  logic [NB_DATA-1:0] w_write_data;
  logic [NB_REG-1:0]  w_dest;
  logic               w_we;
  logic [NB_REG-1:0]  w_dump_rd_addr;
  logic [NB_DATA-1:0] w_dump_rd_data;

  dump_state_e        r_state;
  logic               r_dump_valid;
  logic [NB_DATA-1:0] r_dump_data;
  logic [NB_REG-1:0]  r_dump_index;
  logic               r_dump_done;

  dump_state_e        w_state_next;
  logic               w_dump_valid_next;
  logic [NB_DATA-1:0] w_dump_data_next;
  logic [NB_REG-1:0]  w_dump_index_next;
  logic               w_dump_done_next;

  // Link writes override both the data source and the destination.
  assign w_write_data = i_WB_r31_ctrl   ? NB_DATA'(i_WB_pc) :
                        i_WB_mem_to_reg ? i_WB_mem_data     : i_WB_alu_result;
  assign w_dest       = i_WB_r31_ctrl ? RA_ADDR : i_WB_selected_reg;
  assign w_we         = i_WB_reg_write | i_WB_r31_ctrl;

  assign o_WB_write_data = w_write_data;

  register_array #(
    .NB_DATA (NB_DATA),
    .NB_REG  (NB_REG)
  ) u_register_array (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_we          (w_we),
    .i_waddr       (w_dest),
    .i_wdata       (w_write_data),
    .i_rs_addr     (i_ID_rs_addr),
    .i_rt_addr     (i_ID_rt_addr),
    .i_dump_addr   (w_dump_rd_addr),
    .o_rs_data_c   (o_ID_rs_data),
    .o_rt_data_c   (o_ID_rt_data),
    .o_dump_data_c (w_dump_rd_data)
  );

  // While sending, look ahead to the next index so it can load on accept.
  assign w_dump_rd_addr = (r_state == DUMP_SEND) ? (r_dump_index + NB_REG'(1)) : ZERO_ADDR;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state      <= DUMP_IDLE;
      r_dump_valid <= 1'b0;
      r_dump_data  <= '0;
      r_dump_index <= '0;
      r_dump_done  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_dump_valid <= w_dump_valid_next;
      r_dump_data  <= w_dump_data_next;
      r_dump_index <= w_dump_index_next;
      r_dump_done  <= w_dump_done_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_dump_valid_next = r_dump_valid;
    w_dump_data_next  = r_dump_data;
    w_dump_index_next = r_dump_index;
    w_dump_done_next  = 1'b0;
    case (r_state)
      DUMP_IDLE: begin
        if (i_dump_start) begin
          w_dump_valid_next = 1'b1;
          w_dump_data_next  = w_dump_rd_data;
          w_dump_index_next = ZERO_ADDR;
          w_state_next      = DUMP_SEND;
        end
      end
      DUMP_SEND: begin
        if (i_dump_ready) begin
          if (r_dump_index == LAST_IDX) begin
            w_dump_valid_next = 1'b0;
            w_dump_done_next  = 1'b1;
            w_state_next      = DUMP_DONE;
          end else begin
            w_dump_index_next = r_dump_index + NB_REG'(1);
            w_dump_data_next  = w_dump_rd_data;
          end
        end
      end
      DUMP_DONE: begin
        w_state_next = DUMP_IDLE;
      end
      default: begin
        w_state_next = DUMP_IDLE;
      end
    endcase
  end

  assign o_dump_valid = r_dump_valid;
  assign o_dump_data  = r_dump_data;
  assign o_dump_index = r_dump_index;
  assign o_dump_done  = r_dump_done;

endmodule

// File: tb/tb_wb_register_bank.sv
// Scoreboard bench for wb_register_bank: stimulus queues expected read and
// dump responses, a negedge monitor pops and compares them.
module tb_wb_register_bank;
  import wb_register_bank_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_WB_reg_write, i_WB_mem_to_reg, i_WB_r31_ctrl;
  logic [31:0] i_WB_mem_data, i_WB_alu_result, i_WB_pc;
  logic [4:0]  i_WB_selected_reg, i_ID_rs_addr, i_ID_rt_addr;
  logic [31:0] o_ID_rs_data, o_ID_rt_data, o_WB_write_data;
  logic        i_dump_start, i_dump_ready;
  logic        o_dump_valid, o_dump_done;
  logic [31:0] o_dump_data;
  logic [4:0]  o_dump_index;

  always #5 clk = ~clk;

  wb_register_bank #(.NB_DATA(32), .NB_REG(5), .NB_PC(32)) dut (
    .i_clock           (clk),
    .i_reset           (i_reset),
    .i_WB_reg_write    (i_WB_reg_write),
    .i_WB_mem_to_reg   (i_WB_mem_to_reg),
    .i_WB_mem_data     (i_WB_mem_data),
    .i_WB_alu_result   (i_WB_alu_result),
    .i_WB_selected_reg (i_WB_selected_reg),
    .i_WB_r31_ctrl     (i_WB_r31_ctrl),
    .i_WB_pc           (i_WB_pc),
    .i_ID_rs_addr      (i_ID_rs_addr),
    .i_ID_rt_addr      (i_ID_rt_addr),
    .o_ID_rs_data      (o_ID_rs_data),
    .o_ID_rt_data      (o_ID_rt_data),
    .o_WB_write_data   (o_WB_write_data),
    .i_dump_start      (i_dump_start),
    .i_dump_ready      (i_dump_ready),
    .o_dump_valid      (o_dump_valid),
    .o_dump_data       (o_dump_data),
    .o_dump_index      (o_dump_index),
    .o_dump_done       (o_dump_done)
  );

  typedef struct {
    int          tag;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] wd;
    bit          idle;
  } rd_exp_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } dump_exp_t;

  rd_exp_t     q_rd[$];
  dump_exp_t   q_dump[$];
  logic [31:0] m_regs [32];
  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          tag_cnt = 0;
  logic        chk_en = 1'b0;

  task automatic cmp(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s #%0d: got %h expected %h", nm, tag, act, exp_v);
    end
  endtask

  // Monitor: read checks on strobe, dump words on handshake, stall stability.
  rd_exp_t     m_rd;
  dump_exp_t   m_dw;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [4:0]  prev_idx;

  always @(negedge clk) begin
    if (chk_en) begin
      if (q_rd.size() == 0) begin
        cmp("read_underflow", 0, 32'd1, 32'd0);
      end else begin
        m_rd = q_rd.pop_front();
        cmp("rs_data", m_rd.tag, o_ID_rs_data, m_rd.rs);
        cmp("rt_data", m_rd.tag, o_ID_rt_data, m_rd.rt);
        cmp("wb_data", m_rd.tag, o_WB_write_data, m_rd.wd);
        if (m_rd.idle) begin
          cmp("idle_valid", m_rd.tag, 32'(o_dump_valid), 32'd0);
          cmp("idle_done",  m_rd.tag, 32'(o_dump_done),  32'd0);
          cmp("idle_data",  m_rd.tag, o_dump_data,       32'd0);
          cmp("idle_index", m_rd.tag, 32'(o_dump_index), 32'd0);
        end
      end
    end
    if (prev_stall) begin
      cmp("stall_valid", 32'(prev_idx), 32'(o_dump_valid), 32'd1);
      cmp("stall_data",  32'(prev_idx), o_dump_data, prev_data);
      cmp("stall_index", 32'(prev_idx), 32'(o_dump_index), 32'(prev_idx));
    end
    prev_stall = o_dump_valid && !i_dump_ready;
    prev_data  = o_dump_data;
    prev_idx   = o_dump_index;
    if (o_dump_valid && i_dump_ready) begin
      if (q_dump.size() == 0) begin
        cmp("dump_extra_word", 32'(o_dump_index), 32'd1, 32'd0);
      end else begin
        m_dw = q_dump.pop_front();
        cmp("dump_index", 32'(m_dw.idx), 32'(o_dump_index), 32'(m_dw.idx));
        cmp("dump_data",  32'(m_dw.idx), o_dump_data, m_dw.data);
      end
    end
    if (o_dump_done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] ers, input logic [31:0] ert,
                          input logic [31:0] ewd, input bit idle);
    rd_exp_t e;
    i_ID_rs_addr = rs;
    i_ID_rt_addr = rt;
    e.tag  = tag_cnt++;
    e.rs   = ers;
    e.rt   = ert;
    e.wd   = ewd;
    e.idle = idle;
    q_rd.push_back(e);
    chk_en = 1'b1;
    step();
    chk_en = 1'b0;
  endtask

  task automatic push_dump(input int last);
    dump_exp_t d;
    for (int i = 0; i <= last; i++) begin
      d.idx  = 5'(i);
      d.data = m_regs[i];
      q_dump.push_back(d);
    end
  endtask

  // Waits for the done count to reach target; reports cycles taken.
  task automatic wait_done(input int target, input int budget, input bit toggle, output int cycles);
    cycles = 0;
    for (int k = 1; k <= budget; k++) begin
      if (toggle) begin
        i_dump_ready = k[0];
        i_dump_start = (k == 6);
      end
      step();
      if (done_cnt >= target) begin
        cycles = k;
        break;
      end
    end
    i_dump_start = 1'b0;
    n_vec++;
    if (cycles == 0) begin
      n_err++;
      $display("FAIL dump_timeout: done count %0d, wanted %0d", done_cnt, target);
    end
  endtask

  int cyc;

  initial begin
    i_reset = 1'b0;
    i_WB_reg_write = 1'b0; i_WB_mem_to_reg = 1'b0; i_WB_r31_ctrl = 1'b0;
    i_WB_mem_data = '0; i_WB_alu_result = '0; i_WB_pc = '0; i_WB_selected_reg = '0;
    i_ID_rs_addr = '0; i_ID_rt_addr = '0;
    i_dump_start = 1'b0; i_dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    step();
    step();
    read_chk(5'd5, 5'd31, 32'h0, 32'h0, 32'h0, 1'b1);
    i_reset = 1'b1;
    read_chk(5'd5, 5'd31, 32'h0, 32'h0, 32'h0, 1'b1);

    // Full dump of a freshly reset file, ready held high.
    push_dump(31);
    i_dump_ready = 1'b1;
    i_dump_start = 1'b1;
    step();
    i_dump_start = 1'b0;
    wait_done(1, 60, 1'b0, cyc);
    cmp("done_latency", 0, 32'(cyc), 32'd33);
    i_dump_ready = 1'b0;
    step();

    // ALU write with same-cycle write-through on rs, then on rt.
    i_WB_reg_write = 1'b1; i_WB_mem_to_reg = 1'b0;
    i_WB_alu_result = 32'h0000_1234; i_WB_selected_reg = 5'd7;
    read_chk(5'd7, 5'd31, 32'h1234, 32'h0, 32'h1234, 1'b0);
    m_regs[7] = 32'h1234;
    i_WB_alu_result = 32'hA5A5_0000; i_WB_selected_reg = 5'd9;
    read_chk(5'd0, 5'd9, 32'h0, 32'hA5A5_0000, 32'hA5A5_0000, 1'b0);
    m_regs[9] = 32'hA5A5_0000;
    i_WB_alu_result = 32'h0000_0044; i_WB_selected_reg = 5'd4;
    read_chk(5'd7, 5'd4, 32'h1234, 32'h44, 32'h44, 1'b0);
    m_regs[4] = 32'h44;

    // reg_write low: no commit, no write-through.
    i_WB_reg_write = 1'b0; i_WB_alu_result = 32'h0000_0999; i_WB_selected_reg = 5'd7;
    read_chk(5'd7, 5'd9, 32'h1234, 32'hA5A5_0000, 32'h999, 1'b0);

    // Load aimed at r0 is discarded.
    i_WB_reg_write = 1'b1; i_WB_mem_to_reg = 1'b1;
    i_WB_mem_data = 32'hDEAD_BEEF; i_WB_selected_reg = 5'd0;
    read_chk(5'd0, 5'd7, 32'h0, 32'h1234, 32'hDEAD_BEEF, 1'b0);
    i_WB_reg_write = 1'b0;
    read_chk(5'd0, 5'd0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Link write: r31 <- pc regardless of reg_write; selected_reg ignored.
    i_WB_r31_ctrl = 1'b1; i_WB_pc = 32'h0000_0048;
    i_WB_selected_reg = 5'd4; i_WB_mem_data = 32'hFFFF_0000;
    read_chk(5'd31, 5'd4, 32'h48, 32'h44, 32'h48, 1'b0);
    m_regs[31] = 32'h48;
    i_WB_r31_ctrl = 1'b0; i_WB_mem_to_reg = 1'b0; i_WB_alu_result = '0;
    read_chk(5'd31, 5'd4, 32'h48, 32'h44, 32'h0, 1'b0);

    // Dump with ready toggling and a stray start mid-dump.
    push_dump(31);
    i_dump_ready = 1'b0;
    i_dump_start = 1'b1;
    step();
    i_dump_start = 1'b0;
    wait_done(2, 200, 1'b1, cyc);
    i_dump_ready = 1'b0;
    step();

    // Reset while index 10 is on the bus: abort, no done, file cleared.
    push_dump(10);
    i_dump_ready = 1'b1;
    i_dump_start = 1'b1;
    step();
    i_dump_start = 1'b0;
    repeat (10) step();
    i_reset = 1'b0;
    step();
    read_chk(5'd7, 5'd31, 32'h0, 32'h0, 32'h0, 1'b1);
    i_reset = 1'b1;
    i_dump_ready = 1'b0;
    read_chk(5'd4, 5'd9, 32'h0, 32'h0, 32'h0, 1'b1);
    repeat (3) step();

    cmp("done_pulses", 0, 32'(done_cnt), 32'd2);
    cmp("dump_words_left", 0, 32'(q_dump.size()), 32'd0);
    cmp("reads_left", 0, 32'(q_rd.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
